// File: rtl/circular_buffer_fifo_pkg.sv
// -----------------------------------------------------------------------------
// circular_buffer_fifo_pkg
// Shared helpers for the circular buffer FIFO.
//   DEFAULT_BUFFER_SIZE : default capacity in words
//   cnt_width()         : width of an occupancy counter that holds 0..size
//   ptr_width()         : width of a pointer that holds 0..size-1
//   ptr_wrap()          : (ptr + inc) mod size. It uses a single conditional
//                         subtract, so the caller must keep ptr < size and
//                         inc <= size.
// -----------------------------------------------------------------------------
package circular_buffer_fifo_pkg;

    localparam int DEFAULT_BUFFER_SIZE = 32;

    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                             input int unsigned inc,
                                             input int unsigned size);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= size) begin
            sum = sum - size;
        end
        return sum;
    endfunction

endpackage

// File: rtl/circular_buffer_fifo_mem.sv
// -----------------------------------------------------------------------------
// circular_buffer_fifo_mem
// Word storage for the circular FIFO. It has a W_PARAM-word synchronous write
// port and an R_PARAM-word combinational read port. A multi-word access may
// straddle the end of the array: every word address wraps on its own.
// Ports:
//   clk     : clock
//   we      : write strobe; all W_PARAM words are written together
//   wr_ptr  : address of write word 0
//   wdata   : write words; word k is at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_ptr  : address of read word 0
//   rdata   : read words; word 0 is in the LSBs
// -----------------------------------------------------------------------------
module circular_buffer_fifo_mem
    import circular_buffer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 32,
    parameter int W_PARAM     = 1,
    parameter int R_PARAM     = 1,
    parameter int PTR_W       = 5
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [PTR_W-1:0]              wr_ptr,
    input  logic [DATA_WIDTH*W_PARAM-1:0] wdata,
    input  logic [PTR_W-1:0]              rd_ptr,
    output logic [DATA_WIDTH*R_PARAM-1:0] rdata
);

    // The array has no reset, so the tools can map it to distributed RAM.
    logic [DATA_WIDTH-1:0] mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]      wr_addr [W_PARAM];
    logic [PTR_W-1:0]      rd_addr [R_PARAM];

    for (genvar gi = 0; gi < W_PARAM; gi++) begin : g_wr_addr
        assign wr_addr[gi] = PTR_W'(ptr_wrap(32'(wr_ptr), gi, BUFFER_SIZE));
    end

    for (genvar gi = 0; gi < R_PARAM; gi++) begin : g_rd
        assign rd_addr[gi] = PTR_W'(ptr_wrap(32'(rd_ptr), gi, BUFFER_SIZE));
        assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[gi]];
    end

    // A single process writes every word. This keeps the array under one
    // driver even when W_PARAM > 1.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < W_PARAM; k++) begin
                mem_q[wr_addr[k]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/circular_buffer_fifo.sv
// -----------------------------------------------------------------------------
// circular_buffer_fifo
// First-word-fall-through circular FIFO with a valid/ready style interface.
// Each accepted write pushes W_PARAM words. Each accepted read pops R_PARAM
// words.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset (clears the pointers and count)
//   write_en  : write request; taken only while ready
//   read_en   : pop request; taken only while valid
//   inp       : W_PARAM write words; word 0 is in the LSBs and is stored first
//   full      : count == BUFFER_SIZE
//   empty     : count == 0
//   ready     : free space >= W_PARAM
//   valid     : count >= R_PARAM
//   data_out  : R_PARAM words from the read pointer; the oldest is in the LSBs
// Optional, when CIRC_BUF_ERR_FLAGS_EN is defined:
//   overflow  : sticky; set by write_en while not ready
//   underflow : sticky; set by read_en while not valid
//   Only rst clears these two flags.
// -----------------------------------------------------------------------------
module circular_buffer_fifo
    import circular_buffer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
    parameter int W_PARAM     = 1,
    parameter int R_PARAM     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [DATA_WIDTH*W_PARAM-1:0] inp,
    output logic                          full,
    output logic                          empty,
    output logic                          ready,
    output logic                          valid,
    output logic [DATA_WIDTH*R_PARAM-1:0] data_out
`ifdef CIRC_BUF_ERR_FLAGS_EN
    ,
    output logic                          overflow,
    output logic                          underflow
`endif
);

    localparam int PTR_W = ptr_width(BUFFER_SIZE);
    localparam int CNT_W = cnt_width(BUFFER_SIZE);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             wr_accept, rd_accept;

    // All flags come from the registered count before the edge. A full
    // buffer therefore refuses a write even when a pop happens in the
    // same cycle.
    assign full  = (count_q == CNT_W'(BUFFER_SIZE));
    assign empty = (count_q == '0);
    assign ready = (count_q <= CNT_W'(BUFFER_SIZE - W_PARAM));
    assign valid = (count_q >= CNT_W'(R_PARAM));

    assign wr_accept = write_en & ready & ~rst;
    assign rd_accept = read_en  & valid & ~rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = PTR_W'(ptr_wrap(32'(wr_ptr_q), W_PARAM, BUFFER_SIZE));
        end
        if (rd_accept) begin
            rd_ptr_d = PTR_W'(ptr_wrap(32'(rd_ptr_q), R_PARAM, BUFFER_SIZE));
        end
        count_d = count_q
                + (wr_accept ? CNT_W'(W_PARAM) : '0)
                - (rd_accept ? CNT_W'(R_PARAM) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    circular_buffer_fifo_mem #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BUFFER_SIZE (BUFFER_SIZE),
        .W_PARAM     (W_PARAM),
        .R_PARAM     (R_PARAM),
        .PTR_W       (PTR_W)
    ) u_mem (
        .clk    (clk),
        .we     (wr_accept),
        .wr_ptr (wr_ptr_q),
        .wdata  (inp),
        .rd_ptr (rd_ptr_q),
        .rdata  (data_out)
    );

`ifdef CIRC_BUF_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (write_en && !ready) overflow_q  <= 1'b1;
            if (read_en  && !valid) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_circular_buffer_fifo.sv
// -----------------------------------------------------------------------------
// tb_circular_buffer_fifo
// Directed bench for two instances of circular_buffer_fifo:
//   u_a : DATA_WIDTH=34, BUFFER_SIZE=32, W=R=1
//   u_b : DATA_WIDTH=8,  BUFFER_SIZE=10, W=2, R=3
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// If CIRC_BUF_ERR_FLAGS_EN is defined, the sticky error flags are also covered.
// -----------------------------------------------------------------------------
module tb_circular_buffer_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_we = 1'b0, a_re = 1'b0;
    logic [33:0] a_inp = '0;
    logic        a_full, a_empty, a_ready, a_valid;
    logic [33:0] a_dout;

    logic        b_we = 1'b0, b_re = 1'b0;
    logic [15:0] b_inp = '0;
    logic        b_full, b_empty, b_ready, b_valid;
    logic [23:0] b_dout;

`ifdef CIRC_BUF_ERR_FLAGS_EN
    logic a_ovf, a_unf, b_ovf, b_unf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] vec14 [14] = '{34'h0_0002_DB6E, 34'h3_FFFF_1EB0, 34'h0_0000_0001,
                                34'h2_AAAA_5555, 34'h1_5555_AAAA, 34'h0_DEAD_BEEF,
                                34'h3_0000_0000, 34'h0_FFFF_FFFF, 34'h1_2345_6789,
                                34'h2_8765_4321, 34'h0_0000_0000, 34'h3_FFFF_FFFF,
                                34'h1_0F0F_0F0F, 34'h2_F0F0_F0F0};

    circular_buffer_fifo #(
        .DATA_WIDTH(34), .BUFFER_SIZE(32), .W_PARAM(1), .R_PARAM(1)
    ) u_a (
        .clk(clk), .rst(rst), .write_en(a_we), .read_en(a_re), .inp(a_inp),
        .full(a_full), .empty(a_empty), .ready(a_ready), .valid(a_valid),
        .data_out(a_dout)
`ifdef CIRC_BUF_ERR_FLAGS_EN
        , .overflow(a_ovf), .underflow(a_unf)
`endif
    );

    circular_buffer_fifo #(
        .DATA_WIDTH(8), .BUFFER_SIZE(10), .W_PARAM(2), .R_PARAM(3)
    ) u_b (
        .clk(clk), .rst(rst), .write_en(b_we), .read_en(b_re), .inp(b_inp),
        .full(b_full), .empty(b_empty), .ready(b_ready), .valid(b_valid),
        .data_out(b_dout)
`ifdef CIRC_BUF_ERR_FLAGS_EN
        , .overflow(b_ovf), .underflow(b_unf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle stimulus drivers (no checking inside)
    task automatic a_push(input logic [33:0] d);
        a_we = 1'b1; a_inp = d;
        tick();
        a_we = 1'b0;
    endtask

    task automatic a_pop();
        a_re = 1'b1;
        tick();
        a_re = 1'b0;
    endtask

    task automatic b_push(input logic [7:0] w0, input logic [7:0] w1);
        b_we = 1'b1; b_inp = {w1, w0};
        tick();
        b_we = 1'b0;
    endtask

    task automatic b_pop();
        b_re = 1'b1;
        tick();
        b_re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_a_empty got %b exp 1", a_empty); end
        n_checks++; if (a_full  !== 1'b0) begin n_fail++; $display("FAIL reset_a_full got %b exp 0", a_full); end
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready got %b exp 1", a_ready); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %b exp 0", a_valid); end
        n_checks++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL reset_b_empty got %b exp 1", b_empty); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready got %b exp 1", b_ready); end
        n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %b exp 0", b_valid); end
        $display("test_reset done");
    endtask

    task automatic test_fill_drain14();
        for (int i = 0; i < 14; i++) begin
            a_push(vec14[i]);
            if (i == 0) begin
                n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL fd14_valid_latency got %b exp 1", a_valid); end
            end
        end
        n_checks++; if (a_empty !== 1'b0) begin n_fail++; $display("FAIL fd14_not_empty got %b exp 0", a_empty); end
        n_checks++; if (a_full  !== 1'b0) begin n_fail++; $display("FAIL fd14_not_full got %b exp 0", a_full); end
        for (int i = 0; i < 14; i++) begin
            n_checks++; if (a_dout !== vec14[i]) begin n_fail++; $display("FAIL fd14_data[%0d] got %h exp %h", i, a_dout, vec14[i]); end
            a_pop();
        end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL fd14_empty_end got %b exp 1", a_empty); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL fd14_valid_end got %b exp 0", a_valid); end
        $display("test_fill_drain14 done");
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) a_push({2'b01, 32'hC0DE_0000 + 32'(i)});
        n_checks++; if (a_full  !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", a_full); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", a_ready); end
        a_push(34'h1234);
        n_checks++; if (a_full  !== 1'b1) begin n_fail++; $display("FAIL full_after_ovf got %b exp 1", a_full); end
        for (int i = 0; i < 32; i++) begin
            n_checks++; if (a_dout !== {2'b01, 32'hC0DE_0000 + 32'(i)}) begin n_fail++; $display("FAIL full_data[%0d] got %h exp %h", i, a_dout, {2'b01, 32'hC0DE_0000 + 32'(i)}); end
            a_pop();
        end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL full_empty_end got %b exp 1", a_empty); end
        $display("test_full done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) a_push(34'(1000 + i));
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (a_dout !== 34'(1000 + i)) begin n_fail++; $display("FAIL wrap20[%0d] got %h exp %h", i, a_dout, 34'(1000 + i)); end
            a_pop();
        end
        for (int i = 0; i < 30; i++) a_push(34'(2000 + i));
        for (int i = 0; i < 30; i++) begin
            n_checks++; if (a_dout !== 34'(2000 + i)) begin n_fail++; $display("FAIL wrap30[%0d] got %h exp %h", i, a_dout, 34'(2000 + i)); end
            a_pop();
        end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty_end got %b exp 1", a_empty); end
        $display("test_wrap done");
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp_q [$];
        for (int i = 0; i < 5; i++) begin
            a_push(34'(100 + i));
            exp_q.push_back(34'(100 + i));
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (a_dout !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", c, a_dout, exp_q[0]); end
            a_we = 1'b1; a_re = 1'b1; a_inp = 34'(200 + c);
            tick();
            exp_q.push_back(34'(200 + c));
            void'(exp_q.pop_front());
        end
        a_we = 1'b0; a_re = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (a_dout !== exp_q[0]) begin n_fail++; $display("FAIL b2b_drain[%0d] got %h exp %h", i, a_dout, exp_q[0]); end
            void'(exp_q.pop_front());
            a_pop();
        end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_count5_empty got %b exp 1", a_empty); end
        for (int i = 0; i < 32; i++) a_push(34'(300 + i));
        // Full with read and write both requested: only the pop is taken.
        a_we = 1'b1; a_re = 1'b1; a_inp = 34'h1234;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        n_checks++; if (a_full  !== 1'b0) begin n_fail++; $display("FAIL b2b_full_rw_full got %b exp 0", a_full); end
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_full_rw_ready got %b exp 1", a_ready); end
        for (int i = 1; i < 32; i++) begin
            n_checks++; if (a_dout !== 34'(300 + i)) begin n_fail++; $display("FAIL b2b_full_drain[%0d] got %h exp %h", i, a_dout, 34'(300 + i)); end
            a_pop();
        end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_count31_empty got %b exp 1", a_empty); end
        $display("test_back_to_back done");
    endtask

    task automatic test_wide();
        b_push(8'd1, 8'd2);
        n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL wide_valid_c2 got %b exp 0", b_valid); end
        b_push(8'd3, 8'd4);
        n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL wide_valid_c4 got %b exp 1", b_valid); end
        b_push(8'd5, 8'd6);
        n_checks++; if (b_dout !== 24'h030201) begin n_fail++; $display("FAIL wide_pop0 got %h exp 030201", b_dout); end
        b_pop();
        n_checks++; if (b_dout !== 24'h060504) begin n_fail++; $display("FAIL wide_pop1 got %h exp 060504", b_dout); end
        b_pop();
        n_checks++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL wide_empty got %b exp 1", b_empty); end
        // Pointers are now at 6. The next traffic wraps through index 9 -> 0.
        b_push(8'd7, 8'd8); b_push(8'd9, 8'd10); b_push(8'd11, 8'd12);
        n_checks++; if (b_dout !== 24'h090807) begin n_fail++; $display("FAIL wide_pop2 got %h exp 090807", b_dout); end
        b_pop();
        b_push(8'd13, 8'd14); b_push(8'd15, 8'd16); b_push(8'd17, 8'd18);
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL wide_ready_c9 got %b exp 0", b_ready); end
        n_checks++; if (b_full  !== 1'b0) begin n_fail++; $display("FAIL wide_full_c9 got %b exp 0", b_full); end
        b_push(8'hAA, 8'hBB);
        n_checks++; if (b_dout !== 24'h0C0B0A) begin n_fail++; $display("FAIL wide_pop3 got %h exp 0c0b0a", b_dout); end
        b_pop();
        n_checks++; if (b_dout !== 24'h0F0E0D) begin n_fail++; $display("FAIL wide_pop4 got %h exp 0f0e0d", b_dout); end
        b_pop();
        n_checks++; if (b_dout !== 24'h121110) begin n_fail++; $display("FAIL wide_pop5 got %h exp 121110", b_dout); end
        b_pop();
        n_checks++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL wide_empty_end got %b exp 1", b_empty); end
        $display("test_wide done");
    endtask

`ifdef CIRC_BUF_ERR_FLAGS_EN
    task automatic test_err_flags();
        do_reset();
        n_checks++; if (a_unf !== 1'b0) begin n_fail++; $display("FAIL err_unf_reset got %b exp 0", a_unf); end
        a_pop();
        tick();
        n_checks++; if (a_unf !== 1'b1) begin n_fail++; $display("FAIL err_unf_set got %b exp 1", a_unf); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf_clear got %b exp 0", a_ovf); end
        for (int i = 0; i < 33; i++) a_push(34'(i));
        a_pop();
        tick();
        n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL err_ovf_sticky got %b exp 1", a_ovf); end
        do_reset();
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf_rst got %b exp 0", a_ovf); end
        n_checks++; if (a_unf !== 1'b0) begin n_fail++; $display("FAIL err_unf_rst got %b exp 0", a_unf); end
        $display("test_err_flags done");
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain14();
        test_full();
        test_wrap();
        test_back_to_back();
        test_wide();
`ifdef CIRC_BUF_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
